// File: rtl/midori_ti_pkg.sv
// Shared constants and types for the Midori64 TI masking front-end.
// MIDORI_COLUMN_RAND_EN selects the reduced column-replicated randomness mode
// (one 32-bit LFSR word per block instead of four).
package midori_ti_pkg;

  localparam int unsigned LFSR_W = 32;
  localparam int unsigned BLK_W  = 64;
  localparam logic [LFSR_W-1:0] LFSR_MASK     = 32'h8020_0003;
  localparam logic [LFSR_W-1:0] SEED_ZERO_SUB = 32'h0000_0001;

`ifdef MIDORI_COLUMN_RAND_EN
  localparam int unsigned FILL_WORDS = 1;
`else
  localparam int unsigned FILL_WORDS = 4;
`endif

  localparam int unsigned RND_W      = FILL_WORDS * LFSR_W;
  localparam int unsigned FILL_CNT_W = 2;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ARMED = 2'd1,
    OUT   = 2'd2
  } state_e;

  typedef struct packed {
    logic [BLK_W-1:0] s0;
    logic [BLK_W-1:0] s1;
    logic [BLK_W-1:0] s2;
  } share_set_t;

  // Replicate column nibble c (cols[15-4c -: 4]) into the four cells of column c.
  function automatic logic [BLK_W-1:0] col_expand(input logic [15:0] cols);
    logic [BLK_W-1:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      r[63-16*c -: 16] = {4{cols[15-4*c -: 4]}};
    end
    return r;
  endfunction

endpackage

// File: rtl/lfsr32_adv32.sv
// Combinational 32-step advance of the 32-bit Galois LFSR.
// Ports: state (current LFSR state), adv_c (state after 32 shifts).
module lfsr32_adv32
  import midori_ti_pkg::*;
(
  input  logic [LFSR_W-1:0] state,
  output logic [LFSR_W-1:0] adv_c
);

  // Right-shifting Galois form: the bit shifted out of the LSB folds the mask back in.
  always_comb begin
    logic [LFSR_W-1:0] s;
    s = state;
    for (int i = 0; i < 32; i++) begin
      s = {1'b0, s[LFSR_W-1:1]} ^ (s[0] ? LFSR_MASK : '0);
    end
    adv_c = s;
  end

endmodule

// File: rtl/midori_share_loader.sv
// Masking front-end: splits a 64-bit plaintext into three Boolean shares
// using fresh LFSR randomness, with valid/ready on both sides.
// Ports: clk, rst_n (async active-low); seed_load/seed reseed the LFSR;
// pt_valid/pt_ready/pt_data plaintext input; sh_valid/sh_ready and
// share0..share2 registered share output.
// Build option: MIDORI_COLUMN_RAND_EN (single-word column-replicated randomness).
module midori_share_loader
  import midori_ti_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED_INIT = 32'hACE1_2345
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_load,
  input  logic [LFSR_W-1:0] seed,
  input  logic             pt_valid,
  output logic             pt_ready,
  input  logic [BLK_W-1:0] pt_data,
  output logic             sh_valid,
  input  logic             sh_ready,
  output logic [BLK_W-1:0] share0,
  output logic [BLK_W-1:0] share1,
  output logic [BLK_W-1:0] share2
);

  state_e                state, state_nxt;
  logic [FILL_CNT_W-1:0] fill_cnt, fill_cnt_nxt;
  logic [LFSR_W-1:0]     lfsr, lfsr_nxt, lfsr_adv;
  logic [RND_W-1:0]      rnd, rnd_nxt;
  share_set_t            shares, shares_nxt;
  logic                  pt_ready_nxt, sh_valid_nxt;
  logic [BLK_W-1:0]      r0, r1;

  lfsr32_adv32 u_adv (
    .state (lfsr),
    .adv_c (lfsr_adv)
  );

  // Mask words drawn from the randomness buffer.
`ifdef MIDORI_COLUMN_RAND_EN
  assign r0 = col_expand(rnd[31:16]);
  assign r1 = col_expand(rnd[15:0]);
`else
  assign r0 = rnd[RND_W-1 -: BLK_W];
  assign r1 = rnd[BLK_W-1:0];
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FILL;
      fill_cnt <= '0;
      lfsr     <= SEED_INIT;
      rnd      <= '0;
      shares   <= '0;
      pt_ready <= 1'b0;
      sh_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      fill_cnt <= fill_cnt_nxt;
      lfsr     <= lfsr_nxt;
      rnd      <= rnd_nxt;
      shares   <= shares_nxt;
      pt_ready <= pt_ready_nxt;
      sh_valid <= sh_valid_nxt;
    end
  end

  // Next-state logic; a reseed overrides every other event.
  always_comb begin
    state_nxt    = state;
    fill_cnt_nxt = fill_cnt;
    lfsr_nxt     = lfsr;
    rnd_nxt      = rnd;
    shares_nxt   = shares;

    if (seed_load) begin
      lfsr_nxt     = (seed == '0) ? SEED_ZERO_SUB : seed;
      state_nxt    = FILL;
      fill_cnt_nxt = '0;
      shares_nxt   = '0;
    end else begin
      case (state)
        FILL: begin
          lfsr_nxt = lfsr_adv;
`ifdef MIDORI_COLUMN_RAND_EN
          rnd_nxt  = lfsr_adv;
`else
          rnd_nxt  = {rnd[RND_W-LFSR_W-1:0], lfsr_adv};
`endif
          if (fill_cnt == FILL_CNT_W'(FILL_WORDS - 1)) begin
            state_nxt    = ARMED;
            fill_cnt_nxt = '0;
          end else begin
            fill_cnt_nxt = fill_cnt + FILL_CNT_W'(1);
          end
        end
        ARMED: begin
          if (pt_valid) begin
            shares_nxt.s0 = r0;
            shares_nxt.s1 = r1;
            shares_nxt.s2 = pt_data ^ r0 ^ r1;
            state_nxt     = OUT;
          end
        end
        OUT: begin
          if (sh_ready) begin
            state_nxt    = FILL;
            fill_cnt_nxt = '0;
          end
        end
        default: begin
          state_nxt    = FILL;
          fill_cnt_nxt = '0;
        end
      endcase
    end

    // Handshake flags are registered copies of the upcoming state.
    pt_ready_nxt = (state_nxt == ARMED);
    sh_valid_nxt = (state_nxt == OUT);
  end

  assign share0 = shares.s0;
  assign share1 = shares.s1;
  assign share2 = shares.s2;

endmodule

// File: tb/tb_midori_share_loader.sv
// Self-checking bench for midori_share_loader: directed reset, latency,
// backpressure and reseed cases, then 100 random blocks against a
// sequence-level randomness model.
module tb_midori_share_loader;
  import midori_ti_pkg::*;

  localparam logic [31:0] TB_SEED_INIT = 32'hACE1_2345;
  localparam logic [31:0] TB_MASK      = 32'h8020_0003;

  logic        clk;
  logic        rst_n;
  logic        seed_load;
  logic [31:0] seed;
  logic        pt_valid;
  logic        pt_ready;
  logic [63:0] pt_data;
  logic        sh_valid;
  logic        sh_ready;
  logic [63:0] share0, share1, share2;

  midori_share_loader #(.SEED_INIT(TB_SEED_INIT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_load (seed_load),
    .seed      (seed),
    .pt_valid  (pt_valid),
    .pt_ready  (pt_ready),
    .pt_data   (pt_data),
    .sh_valid  (sh_valid),
    .sh_ready  (sh_ready),
    .share0    (share0),
    .share1    (share1),
    .share2    (share2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference randomness stream: one 32-bit word = 32 single LFSR steps.
  logic [31:0] m_lfsr;

  function automatic logic [31:0] next_word(input logic [31:0] s);
    logic [31:0] x;
    x = s;
    for (int i = 0; i < 32; i++) begin
      if (x % 2 == 1) x = (x >> 1) ^ TB_MASK;
      else            x = x >> 1;
    end
    return x;
  endfunction

  function automatic logic [63:0] expand_col(input logic [15:0] c);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++)
        r[63-16*i-4*k -: 4] = c[15-4*i -: 4];
    return r;
  endfunction

  function automatic logic col_rep(input logic [63:0] x);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++)
      for (int k = 1; k < 4; k++)
        if (x[63-16*i-4*k -: 4] != x[63-16*i -: 4]) ok = 1'b0;
    return ok;
  endfunction

  // Each accepted plaintext consumes the next FILL_WORDS words of the stream.
  task automatic next_block(output logic [63:0] r0, output logic [63:0] r1);
    logic [31:0] w [4];
    for (int i = 0; i < 4; i++) w[i] = '0;
    for (int i = 0; i < int'(FILL_WORDS); i++) begin
      m_lfsr = next_word(m_lfsr);
      w[i]   = m_lfsr;
    end
`ifdef MIDORI_COLUMN_RAND_EN
    r0 = expand_col(w[0][31:16]);
    r1 = expand_col(w[0][15:0]);
`else
    r0 = {w[0], w[1]};
    r1 = {w[2], w[3]};
`endif
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!pt_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!pt_ready) check_eq("ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_block(input string tag, input logic [63:0] pt,
                             input logic [63:0] r0, input logic [63:0] r1);
    check_eq({tag, "_sh_valid"}, 64'(sh_valid), 64'd1);
    check_eq({tag, "_pt_ready"}, 64'(pt_ready), 64'd0);
    check_eq({tag, "_xor"}, share0 ^ share1 ^ share2, pt);
    check_eq({tag, "_share0"}, share0, r0);
    check_eq({tag, "_share1"}, share1, r1);
`ifdef MIDORI_COLUMN_RAND_EN
    check_eq({tag, "_col_s0"}, 64'(col_rep(share0)), 64'd1);
    check_eq({tag, "_col_s1"}, 64'(col_rep(share1)), 64'd1);
`endif
  endtask

  typedef struct {
    logic [63:0] pt;
    logic [63:0] r0;
    logic [63:0] r1;
  } blk_t;

  initial begin
    int          n;
    logic [63:0] r0, r1, prev0, prev1, snap0, snap1, snap2, pt;
    blk_t        q[$];
    blk_t        b;
    int          acc, cons, cyc;

    rst_n = 1'b0; seed_load = 1'b0; seed = '0;
    pt_valid = 1'b0; pt_data = '0; sh_ready = 1'b0;
    m_lfsr = TB_SEED_INIT;

    repeat (3) @(negedge clk);
    check_eq("rst_pt_ready", 64'(pt_ready), 64'd0);
    check_eq("rst_sh_valid", 64'(sh_valid), 64'd0);
    check_eq("rst_share0", share0, 64'd0);
    check_eq("rst_share1", share1, 64'd0);
    check_eq("rst_share2", share2, 64'd0);

    rst_n = 1'b1;
    wait_ready(n);
    check_eq("first_ready_latency", 64'(n), 64'(FILL_WORDS));

    // Known plaintext, immediate consume.
    pt = 64'h0123_4567_89AB_CDEF;
    pt_data = pt; pt_valid = 1'b1; sh_ready = 1'b1;
    next_block(r0, r1);
    @(negedge clk);
    pt_valid = 1'b0;
    check_block("known", pt, r0, r1);
    prev0 = share0; prev1 = share1;
    wait_ready(n);
    check_eq("refill_latency", 64'(n), 64'(FILL_WORDS + 1));

    // Backpressure: shares held for 10 cycles.
    pt = {$urandom, $urandom};
    pt_data = pt; pt_valid = 1'b1; sh_ready = 1'b0;
    next_block(r0, r1);
    @(negedge clk);
    pt_valid = 1'b0;
    check_block("bp", pt, r0, r1);
    check_eq("bp_fresh_r0", 64'(share0 != prev0), 64'd1);
    check_eq("bp_fresh_r1", 64'(share1 != prev1), 64'd1);
    snap0 = share0; snap1 = share1; snap2 = share2;
    for (int i = 0; i < 10; i++) begin
      pt_valid = 1'b1;
      pt_data  = {$urandom, $urandom};
      @(negedge clk);
      check_eq("bp_sh_valid", 64'(sh_valid), 64'd1);
      check_eq("bp_pt_ready", 64'(pt_ready), 64'd0);
      check_eq("bp_share0", share0, snap0);
      check_eq("bp_share1", share1, snap1);
      check_eq("bp_share2", share2, snap2);
    end
    pt_valid = 1'b0;
    sh_ready = 1'b1;
    @(negedge clk);
    sh_ready = 1'b0;
    check_eq("bp_release_sh_valid", 64'(sh_valid), 64'd0);
    wait_ready(n);
    check_eq("bp_refill_latency", 64'(n), 64'(FILL_WORDS));

    // Zero reseed while shares are held.
    pt = {$urandom, $urandom};
    pt_data = pt; pt_valid = 1'b1;
    next_block(r0, r1);
    @(negedge clk);
    pt_valid = 1'b0;
    check_block("pre_reseed", pt, r0, r1);
    seed_load = 1'b1; seed = 32'h0;
    @(negedge clk);
    seed_load = 1'b0;
    m_lfsr = 32'h0000_0001;
    check_eq("reseed_sh_valid", 64'(sh_valid), 64'd0);
    check_eq("reseed_pt_ready", 64'(pt_ready), 64'd0);
    check_eq("reseed_share0", share0, 64'd0);
    check_eq("reseed_share1", share1, 64'd0);
    check_eq("reseed_share2", share2, 64'd0);
    check_eq("reseed_lfsr", 64'(dut.lfsr), 64'h1);
    wait_ready(n);
    check_eq("reseed_ready_latency", 64'(n), 64'(FILL_WORDS));
    pt = {$urandom, $urandom};
    pt_data = pt; pt_valid = 1'b1;
    next_block(r0, r1);
    @(negedge clk);
    pt_valid = 1'b0;
    check_block("post_reseed", pt, r0, r1);
    sh_ready = 1'b1;
    @(negedge clk);
    sh_ready = 1'b0;
    wait_ready(n);

    // Reseed and plaintext offered in the same ARMED cycle: reseed wins.
    seed = $urandom;
    seed_load = 1'b1; pt_valid = 1'b1; pt_data = {$urandom, $urandom};
    @(negedge clk);
    seed_load = 1'b0; pt_valid = 1'b0;
    m_lfsr = (seed == 32'h0) ? 32'h1 : seed;
    check_eq("collide_sh_valid", 64'(sh_valid), 64'd0);
    check_eq("collide_pt_ready", 64'(pt_ready), 64'd0);
    check_eq("collide_share2", share2, 64'd0);
    wait_ready(n);
    check_eq("collide_ready_latency", 64'(n), 64'(FILL_WORDS));

    // 100 random blocks with random valid/ready.
    acc = 0; cons = 0; cyc = 0;
    while (cons < 100 && cyc < 20000) begin
      check_eq("ready_valid_excl", 64'(pt_ready & sh_valid), 64'd0);
      sh_ready = ($urandom_range(0, 1) == 1);
      if (sh_valid && sh_ready) begin
        if (q.size() == 0) begin
          check_eq("unexpected_block", 64'd1, 64'd0);
        end else begin
          b = q.pop_front();
          check_eq("rand_xor", share0 ^ share1 ^ share2, b.pt);
          check_eq("rand_share0", share0, b.r0);
          check_eq("rand_share1", share1, b.r1);
          cons++;
        end
      end
      pt_valid = ($urandom_range(0, 3) != 0) && (acc < 100);
      pt_data  = {$urandom, $urandom};
      if (pt_ready && pt_valid) begin
        next_block(r0, r1);
        q.push_back('{pt_data, r0, r1});
        acc++;
      end
      @(negedge clk);
      cyc++;
    end
    pt_valid = 1'b0; sh_ready = 1'b0;
    check_eq("rand_accepted", 64'(acc), 64'd100);
    check_eq("rand_consumed", 64'(cons), 64'd100);
    check_eq("rand_leftover", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
